// File: rtl/spi_write_router.sv
// Purpose : buffers APB-side {addr,data} writes in a DEPTH-entry FIFO and hands each
//           data byte to the SPI channel chosen by the top address bits (four-phase valid/ack).
// Latency : push at edge t -> pop at t+1 -> ch_valid visible after t+1; rd_data is 1 cycle.
// Backpr. : wr_ready drops when the FIFO holds DEPTH entries; a rejected write pulses overflow.
//
// Ports   : clk, rst_n (async, active low)
//           wr_valid/wr_ready/wr_addr/wr_data  write request side, overflow pulse, fifo_count
//           ch_valid[NUM_CH] (one-hot), ch_data (shared), ch_ack[NUM_CH]  SPI channel side
//           rd_en/rd_in -> rd_data            registered read-return
// Option  : define SPI_ROUTER_DEDUP_EN to drop an accepted write identical to the last stored pair.

module spi_write_router #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int NUM_CH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_valid,
   output logic                       wr_ready,
   input  logic [ADDR_W-1:0]          wr_addr,
   input  logic [DATA_W-1:0]          wr_data,
   output logic                       overflow,
   output logic [$clog2(DEPTH):0]     fifo_count,
   output logic [NUM_CH-1:0]          ch_valid,
   output logic [DATA_W-1:0]          ch_data,
   input  logic [NUM_CH-1:0]          ch_ack,
   input  logic                       rd_en,
   input  logic [DATA_W-1:0]          rd_in,
   output logic [DATA_W-1:0]          rd_data
);

   localparam int CH_W   = $clog2(NUM_CH);
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int PAIR_W = ADDR_W + DATA_W;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_DRIVE   = 2'd1,
      S_RELEASE = 2'd2
   } state_t;

   state_t              state_q, state_d;

   // FIFO storage holds the full {addr, data} pair; it is deliberately not reset.
   logic [PAIR_W-1:0]   mem [DEPTH];
   logic [PTR_W-1:0]    wr_ptr, rd_ptr;
   logic [CNT_W-1:0]    count_q;
   logic [CH_W-1:0]     sel_q;
   logic [CH_W-1:0]     head_sel;
   logic [DATA_W-1:0]   head_data;
   logic                accept;
   logic                push;
   logic                pop;

   assign wr_ready   = (count_q < CNT_W'(DEPTH));
   assign accept     = wr_valid && wr_ready;
   assign fifo_count = count_q;

   // Head-of-queue decode: the top CH_W address bits split the space into equal regions.
   assign head_sel  = mem[rd_ptr][PAIR_W-1 -: CH_W];
   assign head_data = mem[rd_ptr][DATA_W-1:0];

   // The FSM only takes a new entry while idle; the count is checked before any same-cycle push.
   assign pop = (state_q == S_IDLE) && (count_q != '0);

`ifdef SPI_ROUTER_DEDUP_EN
   logic                last_vld;
   logic [PAIR_W-1:0]   last_pair;
   logic                dup;

   // A duplicate is still handshaken (accepted) but never enters the FIFO.
   assign dup  = last_vld && (last_pair == {wr_addr, wr_data});
   assign push = accept && !dup;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_vld  <= 1'b0;
         last_pair <= '0;
      end else if (push) begin
         last_vld  <= 1'b1;
         last_pair <= {wr_addr, wr_data};
      end
   end
`else
   assign push = accept;
`endif

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {wr_addr, wr_data};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         unique case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Dispatch FSM state register plus the channel select / data captured at pop time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         sel_q   <= '0;
         ch_data <= '0;
      end else begin
         state_q <= state_d;
         if (pop) begin
            sel_q   <= head_sel;
            ch_data <= head_data;
         end
      end
   end

   // Only the selected channel's ack is ever looked at; ch_valid is decoded from state so
   // an asynchronous reset removes it immediately.
   always_comb begin
      state_d  = state_q;
      ch_valid = '0;
      unique case (state_q)
         S_IDLE: begin
            if (pop) begin
               state_d = S_DRIVE;
            end
         end
         S_DRIVE: begin
            ch_valid[sel_q] = 1'b1;
            if (ch_ack[sel_q]) begin
               state_d = S_RELEASE;
            end
         end
         S_RELEASE: begin
            if (!ch_ack[sel_q]) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
         rd_data  <= '0;
      end else begin
         overflow <= wr_valid && !wr_ready;
         rd_data  <= rd_en ? rd_in : '0;
      end
   end

endmodule
